// File: rtl/spiro_pkg.sv
// Shared spirometer definitions: state codes common to the controller and the LED state blocks.
package spiro_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_PREP   = 2'd1,
        ST_MEAS   = 2'd2,
        ST_RESULT = 2'd3
    } spiroState_t;

    localparam int FLOW_W = 16;

    function automatic int unsigned maxTicks(input int unsigned a, input int unsigned b,
                                             input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/spiro_tick_gen.sv
// Free-running prescaler producing a registered one-cycle clock-enable every TICK_DIV cycles.
module spiro_tick_gen #(
    parameter int unsigned TICK_DIV = 12_500_000
) (
    input  logic iClk,
    input  logic iReset,
    input  logic iClear,
    output logic oCE
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    if (TICK_DIV < 2) begin : gBadTickDiv
        $error("spiro_tick_gen: TICK_DIV must be >= 2");
    end

    logic [CNT_W-1:0] cntQ;
    logic             ceQ;
    logic             atEnd;

    assign atEnd = (cntQ == CNT_W'(TICK_DIV - 1));

    always_ff @(posedge iClk) begin
        if (iReset || iClear) begin
            cntQ <= '0;
            ceQ  <= 1'b0;
        end else begin
            cntQ <= atEnd ? '0 : cntQ + CNT_W'(1);
            ceQ  <= atEnd;
        end
    end

    assign oCE = ceQ;

endmodule

// File: rtl/spiro_state_ctrl.sv
// Spirometer master sequencer: IDLE -> PREP -> MEASURE -> RESULT, flow pulse counting and tick output.
// Optional start-button debounce filter enabled by defining SPIRO_DEBOUNCE_EN.
module spiro_state_ctrl
    import spiro_pkg::*;
#(
    parameter int unsigned TICK_DIV     = 12_500_000,
    parameter int unsigned PREP_TICKS   = 4,
    parameter int unsigned MEAS_TICKS   = 24,
    parameter int unsigned RESULT_TICKS = 20,
    parameter int unsigned DEB_CYCLES   = 500_000
) (
    input  logic              iClk,
    input  logic              iReset,
    input  logic              iStart,
    input  logic              iAbort,
    input  logic              iFlowPulse,
    output logic              oCE,
    output logic [1:0]        ovStateMachine,
    output logic [FLOW_W-1:0] ovFlowCount,
    output logic              oBusy,
    output logic              oDone
);

    localparam int unsigned MAX_TICKS = maxTicks(PREP_TICKS, MEAS_TICKS, RESULT_TICKS);
    localparam int          CNT_W     = $clog2(MAX_TICKS) + 1;

    if (DEB_CYCLES < 1) begin : gBadDeb
        $error("spiro_state_ctrl: DEB_CYCLES must be >= 1");
    end

    spiroState_t       stateQ, stateD;
    logic [CNT_W-1:0]  tickCntQ, tickCntD;
    logic [FLOW_W-1:0] flowQ, flowD;
    logic              doneQ, doneD;
    logic [1:0]        syncQ;
    logic              startLvl;
    logic              startPrevQ;
    logic              startEdgeQ;
    logic              prescClr;
    logic              ce;
    logic              lastTick;

    spiro_tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) uTickGen (
        .iClk  (iClk),
        .iReset(iReset),
        .iClear(prescClr),
        .oCE   (ce)
    );

    always_ff @(posedge iClk) begin
        if (iReset) begin
            syncQ <= '0;
        end else begin
            syncQ <= {syncQ[0], iStart};
        end
    end

`ifdef SPIRO_DEBOUNCE_EN
    localparam int DEB_W = $clog2(DEB_CYCLES + 1);

    logic [DEB_W-1:0] debCntQ;
    logic             filtQ;

    // Filtered level only follows the synchronised input after DEB_CYCLES identical samples.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            debCntQ <= '0;
            filtQ   <= 1'b0;
        end else if (syncQ[1] == filtQ) begin
            debCntQ <= '0;
        end else if (debCntQ == DEB_W'(DEB_CYCLES - 1)) begin
            debCntQ <= '0;
            filtQ   <= syncQ[1];
        end else begin
            debCntQ <= debCntQ + DEB_W'(1);
        end
    end

    assign startLvl = filtQ;
`else
    assign startLvl = syncQ[1];
`endif

    // Registered edge pulse gives the fixed three-edge start latency.
    always_ff @(posedge iClk) begin
        if (iReset) begin
            startPrevQ <= 1'b0;
            startEdgeQ <= 1'b0;
        end else begin
            startPrevQ <= startLvl;
            startEdgeQ <= startLvl & ~startPrevQ;
        end
    end

    always_comb begin
        lastTick = 1'b0;
        case (stateQ)
            ST_PREP:   lastTick = (tickCntQ == CNT_W'(PREP_TICKS - 1));
            ST_MEAS:   lastTick = (tickCntQ == CNT_W'(MEAS_TICKS - 1));
            ST_RESULT: lastTick = (tickCntQ == CNT_W'(RESULT_TICKS - 1));
            default:   lastTick = 1'b0;
        endcase
    end

    always_comb begin
        stateD   = stateQ;
        tickCntD = tickCntQ;
        flowD    = flowQ;
        doneD    = 1'b0;
        prescClr = 1'b0;

        if (iAbort && (stateQ != ST_IDLE)) begin
            stateD   = ST_IDLE;
            tickCntD = '0;
            flowD    = '0;
        end else begin
            unique case (stateQ)
                ST_IDLE: begin
                    if (startEdgeQ) begin
                        stateD   = ST_PREP;
                        tickCntD = '0;
                        flowD    = '0;
                        prescClr = 1'b1;
                    end
                end
                ST_PREP: begin
                    if (ce) begin
                        if (lastTick) begin
                            stateD   = ST_MEAS;
                            tickCntD = '0;
                        end else begin
                            tickCntD = tickCntQ + CNT_W'(1);
                        end
                    end
                end
                ST_MEAS: begin
                    if (iFlowPulse && (flowQ != {FLOW_W{1'b1}})) begin
                        flowD = flowQ + FLOW_W'(1);
                    end
                    if (ce) begin
                        if (lastTick) begin
                            stateD   = ST_RESULT;
                            tickCntD = '0;
                            doneD    = 1'b1;
                        end else begin
                            tickCntD = tickCntQ + CNT_W'(1);
                        end
                    end
                end
                ST_RESULT: begin
                    if (startEdgeQ || (ce && lastTick)) begin
                        stateD   = ST_IDLE;
                        tickCntD = '0;
                    end else if (ce) begin
                        tickCntD = tickCntQ + CNT_W'(1);
                    end
                end
                default: begin
                    stateD   = ST_IDLE;
                    tickCntD = '0;
                end
            endcase
        end
    end

    always_ff @(posedge iClk) begin
        if (iReset) begin
            stateQ   <= ST_IDLE;
            tickCntQ <= '0;
            flowQ    <= '0;
            doneQ    <= 1'b0;
        end else begin
            stateQ   <= stateD;
            tickCntQ <= tickCntD;
            flowQ    <= flowD;
            doneQ    <= doneD;
        end
    end

    assign oCE            = ce;
    assign ovStateMachine = stateQ;
    assign ovFlowCount    = flowQ;
    assign oBusy          = (stateQ != ST_IDLE);
    assign oDone          = doneQ;

endmodule
